// File: rtl/gpsdo_ctrl.sv
// GPSDO discipline supervisor: selects the DAC code source (free-run, loop,
// holdover average, manual) and serialises writes through a one-deep slot.
module gpsdo_ctrl #(
    parameter int unsigned DAC_WIDTH       = 16,
    parameter int unsigned DAC_MID         = 32767,
    parameter int unsigned LOCK_CNT        = 4,
    parameter int unsigned UNLOCK_CNT      = 2,
    parameter int unsigned AVG_SHIFT       = 4,
    parameter logic [31:0] HOLDOVER_CYCLES = 32'd2_000_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 ref_valid,
    input  logic                 pll_valid,
    input  logic [DAC_WIDTH-1:0] pll_dac,
    input  logic                 pll_locked,
    input  logic                 manual_en,
    input  logic                 manual_wr,
    input  logic [DAC_WIDTH-1:0] manual_dac,
    output logic                 dac_wr_valid,
    input  logic                 dac_wr_ready,
    output logic [DAC_WIDTH-1:0] dac_wr_data,
    output logic [2:0]           state,
    output logic [DAC_WIDTH-1:0] holdover_dac,
    output logic                 holdover_expired
);

    localparam int unsigned ACC_W = DAC_WIDTH + AVG_SHIFT;
    localparam logic [DAC_WIDTH-1:0] MID_CODE = DAC_WIDTH'(DAC_MID);

    typedef enum logic [2:0] {
        S_FREERUN  = 3'd0,
        S_ACQUIRE  = 3'd1,
        S_LOCKED   = 3'd2,
        S_HOLDOVER = 3'd3,
        S_MANUAL   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          lock_cnt_q, lock_cnt_d;
    logic [31:0]          unlock_cnt_q, unlock_cnt_d;
    logic [31:0]          timer_q, timer_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 valid_q, valid_d;
    logic [DAC_WIDTH-1:0] data_q, data_d;
    logic                 start_q;

    logic                 changing;
    logic                 in_loop_q, in_loop_d;
    logic                 fwd;
    logic                 req;
    logic [DAC_WIDTH-1:0] req_data;

    assign holdover_dac = acc_q[ACC_W-1:AVG_SHIFT];

    always_comb begin
        state_d = state_q;
        if (manual_en && state_q != S_MANUAL) begin
            state_d = S_MANUAL;
        end else if (state_q == S_MANUAL) begin
            if (!manual_en) state_d = S_FREERUN;
        end else if (!en && state_q != S_FREERUN) begin
            state_d = S_FREERUN;
        end else begin
            case (state_q)
                S_FREERUN:  if (en && ref_valid) state_d = S_ACQUIRE;
                S_ACQUIRE: begin
                    if (!ref_valid)
                        state_d = S_FREERUN;
                    else if (pll_valid && pll_locked && lock_cnt_q == 32'(LOCK_CNT - 1))
                        state_d = S_LOCKED;
                end
                S_LOCKED: begin
                    if (!ref_valid)
                        state_d = S_HOLDOVER;
                    else if (pll_valid && !pll_locked && unlock_cnt_q == 32'(UNLOCK_CNT - 1))
                        state_d = S_ACQUIRE;
                end
                S_HOLDOVER: if (ref_valid) state_d = S_ACQUIRE;
                default:    state_d = S_FREERUN;
            endcase
        end
    end

    // A pll_valid counts only while the loop stays in ACQUIRE/LOCKED this cycle.
    always_comb begin
        changing  = (state_d != state_q);
        in_loop_q = (state_q == S_ACQUIRE) || (state_q == S_LOCKED);
        in_loop_d = (state_d == S_ACQUIRE) || (state_d == S_LOCKED);
        fwd       = pll_valid && in_loop_q && in_loop_d;

        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        timer_d      = timer_q;
        acc_d        = acc_q;

        if (changing) begin
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
            timer_d      = '0;
        end else begin
            if (state_q == S_ACQUIRE && pll_valid)
                lock_cnt_d = pll_locked ? lock_cnt_q + 32'd1 : '0;
            if (state_q == S_LOCKED && pll_valid)
                unlock_cnt_d = pll_locked ? '0 : unlock_cnt_q + 32'd1;
            if (state_q == S_HOLDOVER && timer_q != HOLDOVER_CYCLES)
                timer_d = timer_q + 32'd1;
        end

        if (state_q != S_LOCKED && state_d == S_LOCKED)
            acc_d = ACC_W'(pll_dac) << AVG_SHIFT;
        else if (state_q == S_LOCKED && state_d == S_LOCKED && pll_valid)
            acc_d = acc_q + ACC_W'(pll_dac) - (acc_q >> AVG_SHIFT);
    end

    always_comb begin
        req      = 1'b0;
        req_data = MID_CODE;
        if (start_q) begin
            req      = 1'b1;
            req_data = MID_CODE;
        end
        if (changing) begin
            case (state_d)
                S_FREERUN:  begin req = 1'b1; req_data = MID_CODE;     end
                S_HOLDOVER: begin req = 1'b1; req_data = holdover_dac; end
                S_MANUAL:   begin req = 1'b1; req_data = manual_dac;   end
                default:    ;
            endcase
        end else if (state_q == S_MANUAL && manual_wr) begin
            req      = 1'b1;
            req_data = manual_dac;
        end
        if (fwd) begin
            req      = 1'b1;
            req_data = pll_dac;
        end

        valid_d = valid_q;
        data_d  = data_q;
        if (req) begin
            valid_d = 1'b1;
            data_d  = req_data;
        end else if (valid_q && dac_wr_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FREERUN;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            timer_q      <= '0;
            acc_q        <= ACC_W'(MID_CODE) << AVG_SHIFT;
            valid_q      <= 1'b0;
            data_q       <= MID_CODE;
            start_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            timer_q      <= timer_d;
            acc_q        <= acc_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            start_q      <= 1'b0;
        end
    end

    assign state            = state_q;
    assign dac_wr_valid     = valid_q;
    assign dac_wr_data      = data_q;
    assign holdover_expired = (state_q == S_HOLDOVER) && (timer_q == HOLDOVER_CYCLES);

endmodule

// File: tb/tb_gpsdo_ctrl.sv
// Directed bench for gpsdo_ctrl: hand-computed codes, states and write order.
module tb_gpsdo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        ref_valid = 1'b0;
    logic        pll_valid = 1'b0;
    logic [15:0] pll_dac = '0;
    logic        pll_locked = 1'b0;
    logic        manual_en = 1'b0;
    logic        manual_wr = 1'b0;
    logic [15:0] manual_dac = '0;
    logic        dac_wr_valid;
    logic        dac_wr_ready = 1'b1;
    logic [15:0] dac_wr_data;
    logic [2:0]  state;
    logic [15:0] holdover_dac;
    logic        holdover_expired;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] xfers[$];

    gpsdo_ctrl #(
        .DAC_WIDTH(16),
        .DAC_MID(32767),
        .LOCK_CNT(4),
        .UNLOCK_CNT(2),
        .AVG_SHIFT(4),
        .HOLDOVER_CYCLES(32'd10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .ref_valid(ref_valid),
        .pll_valid(pll_valid),
        .pll_dac(pll_dac),
        .pll_locked(pll_locked),
        .manual_en(manual_en),
        .manual_wr(manual_wr),
        .manual_dac(manual_dac),
        .dac_wr_valid(dac_wr_valid),
        .dac_wr_ready(dac_wr_ready),
        .dac_wr_data(dac_wr_data),
        .state(state),
        .holdover_dac(holdover_dac),
        .holdover_expired(holdover_expired)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!reset && dac_wr_valid && dac_wr_ready) xfers.push_back(dac_wr_data);

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pll(input logic [15:0] code, input logic lk);
        pll_valid  = 1'b1;
        pll_dac    = code;
        pll_locked = lk;
        step(1);
        pll_valid  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        step(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_valid", 32'(dac_wr_valid), 0);
        chk("rst_data", 32'(dac_wr_data), 32767);
        chk("rst_hdac", 32'(holdover_dac), 32767);
        chk("rst_exp", 32'(holdover_expired), 0);
        reset = 1'b0;
        step(1);
        chk("start_valid", 32'(dac_wr_valid), 1);
        chk("start_data", 32'(dac_wr_data), 32767);
        step(1);
        chk("start_drop", 32'(dac_wr_valid), 0);
        chk("start_n", 32'(xfers.size()), 1);
        chk("start_x0", 32'(xfers[0]), 32767);
        xfers.delete();

        // acquire and lock
        en = 1'b1;
        ref_valid = 1'b1;
        step(1);
        chk("acq_state", 32'(state), 1);
        chk("acq_noentry", 32'(dac_wr_valid), 0);
        pll(16'd30000, 1'b1);
        chk("fwd_valid", 32'(dac_wr_valid), 1);
        chk("fwd_data", 32'(dac_wr_data), 30000);
        chk("acq_hold", 32'(state), 1);
        pll(16'd30001, 1'b1);
        pll(16'd30002, 1'b1);
        chk("acq_3", 32'(state), 1);
        pll(16'd30003, 1'b1);
        chk("lock_state", 32'(state), 2);
        chk("lock_hdac", 32'(holdover_dac), 30003);
        step(1);
        chk("lock_drain", 32'(dac_wr_valid), 0);
        chk("lock_n", 32'(xfers.size()), 4);
        for (int i = 0; i < 4; i++) chk("lock_x", 32'(xfers[i]), 32'(30000 + i));
        xfers.delete();

        // averager
        pll(16'd31000, 1'b1);
        chk("avg_1", 32'(holdover_dac), 30065);
        repeat (15) pll(16'd31000, 1'b1);
        chk("avg_16", 32'(holdover_dac), 30645);
        chk("avg_state", 32'(state), 2);
        step(1);
        chk("avg_n", 32'(xfers.size()), 16);
        xfers.delete();

        // reference lost with a simultaneous pll update
        ref_valid = 1'b0;
        pll(16'd32767, 1'b1);
        chk("ho_state", 32'(state), 3);
        chk("ho_hdac", 32'(holdover_dac), 30645);
        chk("ho_valid", 32'(dac_wr_valid), 1);
        chk("ho_data", 32'(dac_wr_data), 30645);
        step(1);
        chk("ho_n", 32'(xfers.size()), 1);
        chk("ho_x0", 32'(xfers[0]), 30645);
        step(8);
        chk("ho_exp9", 32'(holdover_expired), 0);
        step(1);
        chk("ho_exp10", 32'(holdover_expired), 1);
        step(3);
        chk("ho_exp13", 32'(holdover_expired), 1);
        chk("ho_stay", 32'(state), 3);
        ref_valid = 1'b1;
        step(1);
        chk("reacq_state", 32'(state), 1);
        chk("reacq_exp", 32'(holdover_expired), 0);
        chk("reacq_valid", 32'(dac_wr_valid), 0);
        xfers.delete();

        // back-pressure: latest code wins
        dac_wr_ready = 1'b0;
        pll(16'd100, 1'b0);
        chk("bp_valid1", 32'(dac_wr_valid), 1);
        chk("bp_data1", 32'(dac_wr_data), 100);
        pll(16'd200, 1'b0);
        pll(16'd300, 1'b0);
        step(2);
        chk("bp_hold", 32'(dac_wr_valid), 1);
        chk("bp_data3", 32'(dac_wr_data), 300);
        chk("bp_none", 32'(xfers.size()), 0);
        dac_wr_ready = 1'b1;
        step(1);
        chk("bp_drop", 32'(dac_wr_valid), 0);
        chk("bp_n", 32'(xfers.size()), 1);
        chk("bp_x0", 32'(xfers[0]), 300);
        chk("bp_state", 32'(state), 1);

        // lock, unlock, relock
        repeat (4) pll(16'd40000, 1'b1);
        chk("relock1", 32'(state), 2);
        pll(16'd41000, 1'b0);
        chk("unlock1", 32'(state), 2);
        pll(16'd42000, 1'b0);
        chk("unlock2", 32'(state), 1);
        repeat (4) pll(16'd40000, 1'b1);
        chk("relock2", 32'(state), 2);
        step(1);
        xfers.delete();

        // manual override
        manual_dac = 16'd5555;
        manual_en = 1'b1;
        step(1);
        chk("man_state", 32'(state), 4);
        chk("man_valid", 32'(dac_wr_valid), 1);
        chk("man_entry", 32'(dac_wr_data), 5555);
        manual_dac = 16'd1234;
        manual_wr = 1'b1;
        step(1);
        manual_wr = 1'b0;
        chk("man_wr", 32'(dac_wr_data), 1234);
        pll(16'd777, 1'b1);
        chk("man_pll_ign", 32'(dac_wr_valid), 0);
        chk("man_stay", 32'(state), 4);
        manual_en = 1'b0;
        step(1);
        chk("man_exit", 32'(state), 0);
        chk("man_mid", 32'(dac_wr_data), 32767);
        step(1);
        chk("man_n", 32'(xfers.size()), 3);
        chk("man_x0", 32'(xfers[0]), 5555);
        chk("man_x1", 32'(xfers[1]), 1234);
        chk("man_x2", 32'(xfers[2]), 32767);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpsdo_ctrl.md
# gpsdo_ctrl

Supervisory controller for the GPSDO disciplining loop. It sits between the reference PLL (DAC code producer) and the AD5683 DAC write path. It chooses which DAC code is written: mid-scale free-run, the live PLL code, an averaged holdover code, or a host manual code. It sequences the writes through a valid/ready handshake and reports the discipline state to the host.

## Interface
- DAC_WIDTH, 16, DAC code width
- DAC_MID, 32767, free-run code
- LOCK_CNT, 4, consecutive locked PLL updates needed to enter LOCKED (≥1)
- UNLOCK_CNT, 2, consecutive unlocked PLL updates needed to leave LOCKED (≥1)
- AVG_SHIFT, 4, holdover averager time constant (2^AVG_SHIFT updates)
- HOLDOVER_CYCLES, 32'd2_000_000_000, clk cycles in HOLDOVER before holdover_expired

Ports:
- clk  in  1  sample clock; the only clock
- reset  in  1  synchronous, active-high
- en  in  1  discipline enable
- ref_valid  in  1  reference detected and valid
- pll_valid  in  1  one-cycle strobe: new pll_dac/pll_locked
- pll_dac  in  DAC_WIDTH  loop DAC code
- pll_locked  in  1  loop lock indication, sampled on pll_valid
- manual_en  in  1  host override
- manual_wr  in  1  one-cycle strobe: write manual_dac
- manual_dac  in  DAC_WIDTH  host DAC code
- dac_wr_valid  out  1  write request
- dac_wr_ready  in  1  DAC path accepts request
- dac_wr_data  out  DAC_WIDTH  code to write
- state  out  3  0 FREERUN, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER, 4 MANUAL
- holdover_dac  out  DAC_WIDTH  averaged code
- holdover_expired  out  1  holdover timer reached HOLDOVER_CYCLES

## Operation
- Reset values: state=FREERUN; dac_wr_valid=0; dac_wr_data=DAC_MID; holdover_dac=DAC_MID; holdover_expired=0; all counters 0.
- Transition priority, evaluated every cycle:
  - manual_en=1 and state≠MANUAL → MANUAL.
  - MANUAL with manual_en=0 → FREERUN.
  - en=0 in ACQUIRE, LOCKED or HOLDOVER → FREERUN.
  - FREERUN with en=1 and ref_valid=1 → ACQUIRE.
  - ACQUIRE with ref_valid=0 → FREERUN.
  - ACQUIRE: on each pll_valid, lock_cnt increments if pll_locked, else clears. The pll_valid with pll_locked that makes lock_cnt reach LOCK_CNT → LOCKED.
  - LOCKED with ref_valid=0 → HOLDOVER.
  - LOCKED: unlock_cnt counts consecutive pll_valid with pll_locked=0 and clears on a locked update. Reaching UNLOCK_CNT → ACQUIRE.
  - HOLDOVER with ref_valid=1 → ACQUIRE.
- lock_cnt, unlock_cnt and the holdover timer clear on every state change.
- Entry writes are requested on the transition edge:
  - FREERUN writes DAC_MID.
  - HOLDOVER writes holdover_dac.
  - MANUAL writes manual_dac.
  - ACQUIRE and LOCKED write nothing on entry.
- Out of reset, the first cycle with reset=0 requests one DAC_MID write.
- Forwarding: pll_valid in ACQUIRE or LOCKED requests a write of pll_dac. This includes the pll_valid that causes ACQUIRE→LOCKED or LOCKED→ACQUIRE.
- pll_valid is ignored in any cycle whose transition leaves ACQUIRE or LOCKED for another state (FREERUN, HOLDOVER, MANUAL). Reason: the loop resets its code when the reference is lost. Such a pll_valid causes no forward, no average update and no count.
- MANUAL: manual_wr requests a write of manual_dac. manual_wr outside MANUAL is ignored.
- Averager:
  - acc has DAC_WIDTH+AVG_SHIFT bits, unsigned; holdover_dac = acc >> AVG_SHIFT.
  - On entry to LOCKED: acc = pll_dac << AVG_SHIFT.
  - Each later pll_valid in LOCKED (not leaving): acc = acc + pll_dac − (acc >> AVG_SHIFT). This cannot overflow.
  - acc holds its value in all other states.
- Holdover timer: 32-bit count of cycles spent in HOLDOVER, saturating at HOLDOVER_CYCLES. holdover_expired = (timer == HOLDOVER_CYCLES). It clears on exit. State stays HOLDOVER after expiry.

## Timing
- Single request slot, latest value wins:
  - A request loads dac_wr_data and sets dac_wr_valid on the next edge.
  - A transfer occurs when dac_wr_valid && dac_wr_ready at a clock edge.
  - dac_wr_valid clears after a transfer unless a new request arrives in that same cycle. In that case valid stays 1 and data takes the new value.
  - A request while valid=1 and ready=0 overwrites dac_wr_data. Valid stays 1 and only the latest code is written.
  - dac_wr_data is otherwise stable while valid=1.
- Latency: pll_valid at edge t → dac_wr_valid=1 with pll_dac after edge t+1. The same holds for manual_wr and for transition-entry writes.
- state, holdover_dac and holdover_expired update one edge after their cause.
- reset asserted mid-transfer: valid drops immediately (next edge) and all reset values apply.

## Test plan
- Reset release, ready=1 → one write of 32767, state=0, dac_wr_valid low after one cycle.
- en=1, ref_valid=1, four pll_valid with locked=1 and codes 30000..30003 → four writes in order; state=2 after the fourth; holdover_dac=30003.
- In LOCKED, 16 updates of 31000 → holdover_dac converges toward 31000. Drop ref_valid in the same cycle as a pll_valid carrying 32767 → state=3, that 32767 is neither written nor averaged, one write of holdover_dac.
- HOLDOVER with HOLDOVER_CYCLES=10 → holdover_expired=1 exactly 10 cycles after entry. ref_valid=1 → state=1, expired=0.
- dac_wr_ready=0 while three pll_valid arrive (100, 200, 300) → valid held; ready=1 → exactly one transfer, data 300.
- manual_en=1 from LOCKED, manual_wr with 1234 → state=4, writes of the entry manual_dac value and then 1234; pll_valid ignored. manual_en=0 → state=0, write 32767.
